// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO pair: shift-add multiply and
// restoring divide, one bit per cycle, with the sign fix applied on the final iteration.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] w_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div_zero_q, div_zero_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Signed ops (op[0]==0) work on magnitudes; the signs are remembered for the fix-up.
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  assign sign_a = ~op[0] & op_a[WIDTH-1];
  assign sign_b = ~op[0] & op_b[WIDTH-1];
  assign mag_a  = sign_a ? -op_a : op_a;
  assign mag_b  = sign_b ? -op_b : op_b;

  // Multiply: b_q is shifted right, the product grows down from the top half of acc_q.
  logic [WIDTH-1:0]   mul_addend;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_acc;
  assign mul_addend = b_q[0] ? a_q : {WIDTH{1'b0}};
  assign mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
  assign mul_acc    = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: a_q shifts dividend bits out and quotient bits in; acc_q holds the remainder.
  logic [WIDTH:0]   div_shift, div_diff, div_rem;
  logic             div_ge;
  logic [WIDTH-1:0] div_quo;
  assign div_shift = {acc_q[WIDTH-1:0], a_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, b_q};
  assign div_diff  = div_shift - {1'b0, b_q};
  assign div_rem   = div_ge ? div_diff : div_shift;
  assign div_quo   = {a_q[WIDTH-2:0], div_ge};

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod_fix = neg_res_q ? -mul_acc : mul_acc;
  assign quo_fix  = div_zero_q ? {WIDTH{1'b1}} : (neg_res_q ? -div_quo : div_quo);
  assign rem_fix  = neg_rem_q ? -div_rem[WIDTH-1:0] : div_rem[WIDTH-1:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          is_div_d   = op[1];
          neg_res_d  = sign_a ^ sign_b;
          neg_rem_d  = sign_a;
          div_zero_d = (op_b == '0);
          a_d        = mag_a;
          b_d        = mag_b;
          acc_d      = '0;
          cnt_d      = '0;
          state_d    = CALC;
          busy_d     = 1'b1;
        end else begin
          if (hi_we) hi_d = w_data;
          if (lo_we) lo_d = w_data;
        end
      end
      CALC: begin
        if (is_div_q) begin
          acc_d = {{(WIDTH-1){1'b0}}, div_rem};
          a_d   = div_quo;
        end else begin
          acc_d = mul_acc;
          b_d   = b_q >> 1;
        end
        // The last iteration's result goes straight into HI/LO through the sign fix.
        if (cnt_q == LAST) begin
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vectors, randomized ops against a
// plain-arithmetic reference model, MTHI/MTLO, ignored starts, back-to-back and reset.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] op_a, op_b, w_data;
  logic        hi_we, lo_we;
  logic [31:0] hi, lo;
  logic        busy, done;

  int compared = 0;
  int mismatched = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .op    (op),
    .op_a  (op_a),
    .op_b  (op_b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .w_data(w_data),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // MIPS-style HI/LO results computed with native arithmetic.
  function automatic void ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] rh, output logic [31:0] rl);
    longint          sp;
    logic [63:0]     up;
    int              sa, sb;
    sa = a;
    sb = b;
    rh = '0;
    rl = '0;
    case (o)
      2'b00: begin
        sp = longint'(sa) * longint'(sb);
        up = sp;
        rh = up[63:32];
        rl = up[31:0];
      end
      2'b01: begin
        up = {32'b0, a} * {32'b0, b};
        rh = up[63:32];
        rl = up[31:0];
      end
      2'b10: begin
        if (b == 32'd0) begin
          rl = 32'hFFFFFFFF;
          rh = a;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          rl = 32'h80000000;
          rh = 32'd0;
        end else begin
          rl = sa / sb;
          rh = sa % sb;
        end
      end
      default: begin
        if (b == 32'd0) begin
          rl = 32'hFFFFFFFF;
          rh = a;
        end else begin
          rl = a / b;
          rh = a % b;
        end
      end
    endcase
  endfunction

  // Drives one operation from a negedge and returns at the negedge where done is seen.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit inject, output logic [31:0] rh, output logic [31:0] rl,
                        output int lat, output bit busy_ok, output bit hold_ok, output bit dead_seen);
    logic [31:0] hi0, lo0;
    hi0 = hi;
    lo0 = lo;
    op = o;
    op_a = a;
    op_b = b;
    start = 1'b1;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    dead_seen = 1'b0;
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clock);
      start = 1'b0;
      hi_we = 1'b0;
      lo_we = 1'b0;
      op = 2'($urandom);
      op_a = $urandom;
      op_b = $urandom;
      if (hi == 32'h0000DEAD) dead_seen = 1'b1;
      if (done) begin
        if (busy) busy_ok = 1'b0;
        lat = k;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      if (hi !== hi0 || lo !== lo0) hold_ok = 1'b0;
      if (inject && k == 5) begin
        start = 1'b1;
        op = ~o;
        op_a = 32'd1000;
        op_b = 32'd3;
        hi_we = 1'b1;
        w_data = 32'h0000DEAD;
      end
    end
    rh = hi;
    rl = lo;
  endtask

  task automatic test_reset();
    #3;
    compared++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_state: hi=%h lo=%h busy=%b done=%b expected all zero", hi, lo, busy, done);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    compared++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_release: busy=%b done=%b expected 0/0", busy, done);
    end
  endtask

  task automatic test_directed();
    logic [1:0]  ov [6];
    logic [31:0] av [6];
    logic [31:0] bv [6];
    logic [31:0] ehv [6];
    logic [31:0] elv [6];
    logic [31:0] rh, rl;
    int          lat;
    bit          bok, hok, dseen;
    ov  = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b11};
    av  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd100, 32'hFFFFFFF9, 32'h80000000, 32'd100};
    bv  = '{32'd7, 32'hFFFFFFFF, 32'd7, 32'd2, 32'hFFFFFFFF, 32'd0};
    ehv = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'd2, 32'hFFFFFFFF, 32'd0, 32'h00000064};
    elv = '{32'hFFFFFFEB, 32'h00000001, 32'd14, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF};
    for (int i = 0; i < 6; i++) begin
      run_op(ov[i], av[i], bv[i], 1'b0, rh, rl, lat, bok, hok, dseen);
      compared++;
      if (lat !== 33) begin
        mismatched++;
        $display("[TB] FAIL directed%0d_latency: got %0d expected 33", i, lat);
      end
      compared++;
      if (rh !== ehv[i] || rl !== elv[i]) begin
        mismatched++;
        $display("[TB] FAIL directed%0d_result: hi=%h lo=%h expected hi=%h lo=%h", i, rh, rl, ehv[i], elv[i]);
      end
      compared++;
      if (!bok || !hok) begin
        mismatched++;
        $display("[TB] FAIL directed%0d_calc: busy_ok=%b hold_ok=%b expected 1/1", i, bok, hok);
      end
    end
    @(negedge clock);
    compared++;
    if (done !== 1'b0 || hi !== 32'h00000064 || lo !== 32'hFFFFFFFF) begin
      mismatched++;
      $display("[TB] FAIL done_one_cycle: done=%b hi=%h lo=%h expected 0/00000064/ffffffff", done, hi, lo);
    end
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] a, b, eh, el, rh, rl;
    int          lat;
    bit          bok, hok, dseen;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom);
      a = ($urandom_range(0, 9) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      ref_model(o, a, b, eh, el);
      run_op(o, a, b, 1'b0, rh, rl, lat, bok, hok, dseen);
      compared++;
      if (rh !== eh || rl !== el || lat !== 33) begin
        mismatched++;
        $display("[TB] FAIL random%0d op=%0d a=%h b=%h: hi=%h lo=%h lat=%0d expected hi=%h lo=%h lat=33",
                 i, o, a, b, rh, rl, lat, eh, el);
      end
    end
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] rh, rl;
    int          lat;
    bit          bok, hok, dseen;
    w_data = 32'h0000BEEF;
    hi_we = 1'b1;
    lo_we = 1'b1;
    @(negedge clock);
    hi_we = 1'b0;
    lo_we = 1'b0;
    compared++;
    if (hi !== 32'h0000BEEF || lo !== 32'h0000BEEF) begin
      mismatched++;
      $display("[TB] FAIL mt_both: hi=%h lo=%h expected 0000beef/0000beef", hi, lo);
    end
    w_data = 32'h00001234;
    hi_we = 1'b1;
    @(negedge clock);
    hi_we = 1'b0;
    compared++;
    if (hi !== 32'h00001234 || lo !== 32'h0000BEEF) begin
      mismatched++;
      $display("[TB] FAIL mthi: hi=%h lo=%h expected 00001234/0000beef", hi, lo);
    end
    w_data = 32'h00005678;
    lo_we = 1'b1;
    @(negedge clock);
    lo_we = 1'b0;
    compared++;
    if (hi !== 32'h00001234 || lo !== 32'h00005678) begin
      mismatched++;
      $display("[TB] FAIL mtlo: hi=%h lo=%h expected 00001234/00005678", hi, lo);
    end
    w_data = 32'h0BAD0BAD;
    hi_we = 1'b1;
    lo_we = 1'b1;
    run_op(2'b01, 32'd3, 32'd5, 1'b0, rh, rl, lat, bok, hok, dseen);
    compared++;
    if (!hok || rh !== 32'd0 || rl !== 32'd15) begin
      mismatched++;
      $display("[TB] FAIL start_wins: hold_ok=%b hi=%h lo=%h expected 1/00000000/0000000f", hok, rh, rl);
    end
  endtask

  task automatic test_calc_ignore();
    logic [31:0] eh, el, rh, rl;
    int          lat;
    bit          bok, hok, dseen;
    ref_model(2'b00, 32'h00012345, 32'hFFFF0003, eh, el);
    run_op(2'b00, 32'h00012345, 32'hFFFF0003, 1'b1, rh, rl, lat, bok, hok, dseen);
    compared++;
    if (rh !== eh || rl !== el || lat !== 33) begin
      mismatched++;
      $display("[TB] FAIL calc_ignore_result: hi=%h lo=%h lat=%0d expected hi=%h lo=%h lat=33", rh, rl, lat, eh, el);
    end
    compared++;
    if (dseen || !hok || !bok) begin
      mismatched++;
      $display("[TB] FAIL calc_ignore_hold: dead_seen=%b hold_ok=%b busy_ok=%b expected 0/1/1", dseen, hok, bok);
    end
    @(negedge clock);
    compared++;
    if (hi !== eh || busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL calc_ignore_after: hi=%h busy=%b expected %h/0", hi, busy, eh);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] eh, el, rh, rl;
    int          lat;
    bit          bok, hok, dseen;
    run_op(2'b11, 32'd1000, 32'd7, 1'b0, rh, rl, lat, bok, hok, dseen);
    ref_model(2'b00, 32'hFFFFFF00, 32'h00000100, eh, el);
    run_op(2'b00, 32'hFFFFFF00, 32'h00000100, 1'b0, rh, rl, lat, bok, hok, dseen);
    compared++;
    if (lat !== 33 || rh !== eh || rl !== el || !bok) begin
      mismatched++;
      $display("[TB] FAIL back_to_back: lat=%0d hi=%h lo=%h busy_ok=%b expected lat=33 hi=%h lo=%h busy_ok=1",
               lat, rh, rl, bok, eh, el);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] eh, el, rh, rl;
    int          lat;
    bit          bok, hok, dseen;
    bit          done_seen;
    w_data = 32'hA5A5A5A5;
    hi_we = 1'b1;
    lo_we = 1'b1;
    @(negedge clock);
    hi_we = 1'b0;
    lo_we = 1'b0;
    op = 2'b00;
    op_a = 32'd123;
    op_b = 32'd456;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    compared++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || done !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_mid_async: busy=%b hi=%h lo=%h done=%b expected 0/0/0/0", busy, hi, lo, done);
    end
    done_seen = 1'b0;
    repeat (2) begin
      @(negedge clock);
      if (done) done_seen = 1'b1;
    end
    reset = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (done || busy) done_seen = 1'b1;
    end
    compared++;
    if (done_seen) begin
      mismatched++;
      $display("[TB] FAIL reset_mid_no_done: activity=%b expected 0", done_seen);
    end
    ref_model(2'b10, 32'hFFFFF000, 32'd7, eh, el);
    run_op(2'b10, 32'hFFFFF000, 32'd7, 1'b0, rh, rl, lat, bok, hok, dseen);
    compared++;
    if (lat !== 33 || rh !== eh || rl !== el) begin
      mismatched++;
      $display("[TB] FAIL reset_mid_restart: lat=%0d hi=%h lo=%h expected lat=33 hi=%h lo=%h", lat, rh, rl, eh, el);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op = 2'b00;
    op_a = '0;
    op_b = '0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    w_data = '0;
    test_reset();
    test_directed();
    test_random();
    test_mthi_mtlo();
    test_calc_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
